operand_fetch: RTL

//   Pipeline stage directly upstream of the GPU register file. Accepts decoded

---
 rtl/operand_fetch_pkg.sv | 19 +
 rtl/operand_bypass.sv | 35 +++
 rtl/operand_fetch.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types and default sizing for the operand-fetch stage.
package operand_fetch_pkg;

    localparam int unsigned OF_REG_COUNT  = 32;
    localparam int unsigned OF_REG_WIDTH  = 32;
    localparam int unsigned OF_META_WIDTH = 16;
    localparam int unsigned OF_ADDR_WIDTH = $clog2(OF_REG_COUNT);

    typedef logic [OF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [OF_REG_WIDTH-1:0]  reg_data_t;
    typedef logic [OF_META_WIDTH-1:0] meta_t;

    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        meta_t     meta;
    } fetch_slot_t;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand writeback compare/select used by operand_fetch when
// OPERAND_FETCH_BYPASS_EN is defined.
module operand_bypass
    import operand_fetch_pkg::*;
#(
    parameter int unsigned AW = OF_ADDR_WIDTH,
    parameter int unsigned DW = OF_REG_WIDTH
) (
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] rf_data,
    input  logic          fwd_en,
    input  logic [DW-1:0] fwd_data,
    output logic          rd_hit,
    output logic          b_hit,
    output logic [DW-1:0] a_data
);

    // A write landing this cycle beats a captured forward, which beats stale RF data.
    always_comb begin
        rd_hit = wb_en && (wb_addr == rd_addr);
        b_hit  = wb_en && (wb_addr == b_addr);
        a_data = rf_data;
        if (wb_en && (wb_addr == a_addr)) begin
            a_data = wb_data;
        end else if (fwd_en) begin
            a_data = fwd_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: issues register-file reads, aligns the 1-cycle read
// data with its instruction and hands operands to execute.
// Optional feature macro: OPERAND_FETCH_BYPASS_EN (writeback forwarding).
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned REG_COUNT  = OF_REG_COUNT,
    parameter int unsigned REG_WIDTH  = OF_REG_WIDTH,
    parameter int unsigned META_WIDTH = OF_META_WIDTH,
    localparam int unsigned AW        = $clog2(REG_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [AW-1:0]         in_rs1_i,
    input  logic [AW-1:0]         in_rs2_i,
    input  logic [META_WIDTH-1:0] in_meta_i,
    output logic [AW-1:0]         rf_addr_1_o,
    output logic [AW-1:0]         rf_addr_2_o,
    input  logic [REG_WIDTH-1:0]  rf_data_1_i,
    input  logic [REG_WIDTH-1:0]  rf_data_2_i,
    input  logic                  wb_en_i,
    input  logic [AW-1:0]         wb_addr_i,
    input  logic [REG_WIDTH-1:0]  wb_data_i,
    output logic                  rf_wr_en_o,
    output logic [AW-1:0]         rf_addr_3_o,
    output logic [REG_WIDTH-1:0]  rf_wr_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [REG_WIDTH-1:0]  out_op1_o,
    output logic [REG_WIDTH-1:0]  out_op2_o,
    output logic [META_WIDTH-1:0] out_meta_o
);

    typedef struct packed {
        logic [AW-1:0]         rs1;
        logic [AW-1:0]         rs2;
        logic [META_WIDTH-1:0] meta;
    } slot_t;

    slot_t                 a_q;
    logic                  a_valid_q;
    logic                  b_valid_q;
    logic [REG_WIDTH-1:0]  b_op1_q, b_op2_q;
    logic [META_WIDTH-1:0] b_meta_q;
    logic [REG_WIDTH-1:0]  op1_sel, op2_sel;
    logic                  b_free, a_adv, in_fire;

    assign b_free      = ~b_valid_q | out_ready_i;
    assign a_adv       = a_valid_q & b_free;
    assign in_ready_o  = ~a_valid_q | b_free;
    assign in_fire     = in_valid_i & in_ready_o;

    // A stalled slot keeps re-reading its own sources so read data stays current.
    assign rf_addr_1_o = in_fire ? in_rs1_i : a_q.rs1;
    assign rf_addr_2_o = in_fire ? in_rs2_i : a_q.rs2;

    assign rf_wr_en_o   = wb_en_i;
    assign rf_addr_3_o  = wb_addr_i;
    assign rf_wr_data_o = wb_data_i;

    assign out_valid_o = b_valid_q;
    assign out_op1_o   = b_op1_q;
    assign out_op2_o   = b_op2_q;
    assign out_meta_o  = b_meta_q;

`ifdef OPERAND_FETCH_BYPASS_EN
    logic                 fwd1_q, fwd2_q;
    logic [REG_WIDTH-1:0] fwd_data1_q, fwd_data2_q;
    logic [AW-1:0]        b_rs1_q, b_rs2_q;
    logic                 rd_hit1, rd_hit2, b_hit1, b_hit2;

    operand_bypass #(.AW(AW), .DW(REG_WIDTH)) u_bypass_1 (
        .wb_en    (wb_en_i),
        .wb_addr  (wb_addr_i),
        .wb_data  (wb_data_i),
        .rd_addr  (rf_addr_1_o),
        .a_addr   (a_q.rs1),
        .b_addr   (b_rs1_q),
        .rf_data  (rf_data_1_i),
        .fwd_en   (fwd1_q),
        .fwd_data (fwd_data1_q),
        .rd_hit   (rd_hit1),
        .b_hit    (b_hit1),
        .a_data   (op1_sel)
    );

    operand_bypass #(.AW(AW), .DW(REG_WIDTH)) u_bypass_2 (
        .wb_en    (wb_en_i),
        .wb_addr  (wb_addr_i),
        .wb_data  (wb_data_i),
        .rd_addr  (rf_addr_2_o),
        .a_addr   (a_q.rs2),
        .b_addr   (b_rs2_q),
        .rf_data  (rf_data_2_i),
        .fwd_en   (fwd2_q),
        .fwd_data (fwd_data2_q),
        .rd_hit   (rd_hit2),
        .b_hit    (b_hit2),
        .a_data   (op2_sel)
    );

    // Capture writes that race this cycle's read; re-evaluated every cycle because the
    // next read (same addresses while A stalls) already sees anything written earlier.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd_data1_q <= '0;
            fwd_data2_q <= '0;
        end else begin
            fwd1_q      <= rd_hit1;
            fwd2_q      <= rd_hit2;
            fwd_data1_q <= wb_data_i;
            fwd_data2_q <= wb_data_i;
        end
    end
`else
    assign op1_sel = rf_data_1_i;
    assign op2_sel = rf_data_2_i;
`endif

    // Slot A: instruction whose register-file read is in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_valid_q <= 1'b0;
            a_q       <= '0;
        end else if (in_fire) begin
            a_valid_q <= 1'b1;
            a_q       <= '{rs1: in_rs1_i, rs2: in_rs2_i, meta: in_meta_i};
        end else if (a_adv) begin
            a_valid_q <= 1'b0;
        end
    end

    // Slot B: operands presented to execute; snoops writeback while held.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            b_valid_q <= 1'b0;
            b_op1_q   <= '0;
            b_op2_q   <= '0;
            b_meta_q  <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
            b_rs1_q   <= '0;
            b_rs2_q   <= '0;
`endif
        end else if (a_adv) begin
            b_valid_q <= 1'b1;
            b_op1_q   <= op1_sel;
            b_op2_q   <= op2_sel;
            b_meta_q  <= a_q.meta;
`ifdef OPERAND_FETCH_BYPASS_EN
            b_rs1_q   <= a_q.rs1;
            b_rs2_q   <= a_q.rs2;
`endif
        end else begin
            if (out_ready_i) begin
                b_valid_q <= 1'b0;
            end
`ifdef OPERAND_FETCH_BYPASS_EN
            if (b_valid_q && !out_ready_i) begin
                if (b_hit1) b_op1_q <= wb_data_i;
                if (b_hit2) b_op2_q <= wb_data_i;
            end
`endif
        end
    end

endmodule
